// File: rtl/ncpu32k_pc_gen.sv
// Fetch PC sequencer: issues word-aligned fetch requests, tracks in-flight PCs,
// queries the branch predictor on each response and handles redirects/flushes.
module ncpu32k_pc_gen #(
    parameter int              AW         = 32,
    parameter logic [AW-3:0]   RST_VECTOR = '0,
    parameter int              MAX_OUTST  = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ifu_req_valid,
    input  logic          ifu_req_ready,
    output logic [AW-3:0] ifu_req_pc,
    input  logic          ifu_rsp_valid,
    input  logic          ifu_rsp_jmprel,
    output logic          ifu_rsp_keep,
    output logic          bpu_rd,
    output logic [AW-3:0] bpu_insn_pc,
    output logic          bpu_jmprel,
    input  logic          bpu_jmprel_taken,
    input  logic [AW-3:0] bpu_jmp_tgt,
    input  logic          flush_valid,
    input  logic [AW-3:0] flush_pc
);
    localparam int PW = AW - 2;

    typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_t;

    state_t        state_r, state_nxt_s;
    logic [PW-1:0] pc_r, pc_nxt_s;
    logic [2:0]    outst_r, outst_pop_s, outst_nxt_s;
    logic [2:0]    drop_r, drop_nxt_s;
    // Four slots cover the largest legal MAX_OUTST; pointers wrap naturally.
    logic [PW-1:0] fifo_r [4];
    logic [1:0]    wptr_r, rptr_r;

    logic req_valid_s, accept_s, rsp_fire_s, keep_s, taken_s;

    // Next-state and handshake decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: state_nxt_s = ST_RUN;
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_BOOT;
        endcase

        req_valid_s = (state_r == ST_RUN) && (outst_r < 3'(MAX_OUTST));
        accept_s    = req_valid_s & ifu_req_ready;
        // A response with no request in flight is ignored here and flagged by the checker.
        rsp_fire_s  = ifu_rsp_valid & (outst_r != 3'd0);
        keep_s      = rsp_fire_s & (drop_r == 3'd0) & ~flush_valid;
        taken_s     = keep_s & ifu_rsp_jmprel & bpu_jmprel_taken;

        outst_pop_s = outst_r - {2'b00, rsp_fire_s};
        outst_nxt_s = outst_pop_s + {2'b00, accept_s};

        if (flush_valid || taken_s) begin
            drop_nxt_s = outst_nxt_s;
        end else if (rsp_fire_s && (drop_r != 3'd0)) begin
            drop_nxt_s = drop_r - 3'd1;
        end else begin
            drop_nxt_s = drop_r;
        end

        if (flush_valid) begin
            pc_nxt_s = flush_pc;
        end else if (taken_s) begin
            pc_nxt_s = bpu_jmp_tgt;
        end else if (accept_s) begin
            pc_nxt_s = pc_r + PW'(1);
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Sequencer state, PC and in-flight PC FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
            pc_r    <= RST_VECTOR;
            outst_r <= 3'd0;
            drop_r  <= 3'd0;
            wptr_r  <= 2'd0;
            rptr_r  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            outst_r <= outst_nxt_s;
            drop_r  <= drop_nxt_s;
            if (accept_s) begin
                fifo_r[wptr_r] <= pc_r;
                wptr_r         <= wptr_r + 2'd1;
            end
            if (rsp_fire_s) begin
                rptr_r <= rptr_r + 2'd1;
            end
        end
    end

    assign ifu_req_valid = req_valid_s;
    assign ifu_req_pc    = pc_r;
    assign ifu_rsp_keep  = keep_s;
    assign bpu_rd        = keep_s;
    assign bpu_insn_pc   = keep_s ? fifo_r[rptr_r] : '0;
    assign bpu_jmprel    = keep_s & ifu_rsp_jmprel;

    ncpu32k_pc_gen_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (ifu_rsp_valid),
        .outst     (outst_r),
        .drop      (drop_r)
    );
endmodule

// Protocol/invariant checker for the PC sequencer.
module ncpu32k_pc_gen_chk (
    input logic       clk,
    input logic       rst,
    input logic       rsp_valid,
    input logic [2:0] outst,
    input logic [2:0] drop
);
    a_rsp_nonempty: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> (outst != 3'd0))
        else $error("response with no request in flight");
    a_drop_le_outst: assert property (@(posedge clk) disable iff (rst) drop <= outst)
        else $error("drop count exceeds in-flight count");
endmodule
